// File: rtl/riscv_pkg.sv
// riscv_pkg: types and constants shared by the instruction fetch unit and
// the main decoder.
//   fetch_state_e : fetch FSM state encoding
//   NOP_INSTR     : canonical RV32I NOP (addi x0, x0, 0)
//   OP_*          : RV32I major opcodes (instr[6:0])
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH      = 2'd1,
    DRAIN      = 2'd2,
    HOLD       = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches RV32I words from instruction memory over a
// req/ack handshake, buffers one word and offers it to the decoder over a
// valid/ready handshake. PC redirects discard stale fetches.
//
// Ports
//   clk, rst_n                 system clock / async active-low reset
//   imem_req, imem_addr        fetch request and address (held until ack)
//   imem_ack, imem_rdata       memory response
//   redirect, redirect_target  single-cycle PC redirect (bits [1:0] dropped)
//   instr_valid, instr_ready   decoder handshake
//   instr, instr_pc, op, F     buffered word, its PC, opcode and funct3
//   fetch_count                completed decoder handshakes (wraps)
//
// state      | meaning
// FETCH_IDLE | no request; one bubble before the next fetch
// FETCH      | request outstanding at pc, result will be kept
// DRAIN      | request outstanding but redirected; result will be dropped
// HOLD       | buffered word presented to the decoder
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op,
  output logic [2:0]      F,
  output logic [31:0]     fetch_count
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] pc_pending, pc_pending_nxt;
  logic [XLEN-1:0] instr_q, instr_nxt;
  logic [XLEN-1:0] instr_pc_q, instr_pc_nxt;
  logic            valid_q, valid_nxt;
  logic [31:0]     count_q, count_nxt;
  logic [XLEN-1:0] target_aligned;

  assign target_aligned = redirect_target & ~XLEN'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH_IDLE;
      pc         <= XLEN'(RESET_PC);
      pc_pending <= XLEN'(RESET_PC);
      instr_q    <= XLEN'(NOP_INSTR);
      instr_pc_q <= XLEN'(RESET_PC);
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pc_pending <= pc_pending_nxt;
      instr_q    <= instr_nxt;
      instr_pc_q <= instr_pc_nxt;
      valid_q    <= valid_nxt;
      count_q    <= count_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pc_pending_nxt = pc_pending;
    instr_nxt      = instr_q;
    instr_pc_nxt   = instr_pc_q;
    valid_nxt      = valid_q;
    count_nxt      = count_q;

    unique case (state)
      FETCH_IDLE: begin
        // nothing is outstanding, so a redirect here simply retargets pc
        if (redirect) pc_nxt = target_aligned;
        state_nxt = FETCH;
      end
      FETCH: begin
        if (imem_ack && !redirect) begin
          instr_nxt    = imem_rdata;
          instr_pc_nxt = pc;
          valid_nxt    = 1'b1;
          pc_nxt       = pc + XLEN'(PC_STEP);
          state_nxt    = HOLD;
        end else if (imem_ack && redirect) begin
          pc_nxt    = target_aligned;
          state_nxt = FETCH_IDLE;
        end else if (redirect) begin
          // pc keeps driving imem_addr until the stale request is acked
          pc_pending_nxt = target_aligned;
          state_nxt      = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          pc_nxt    = redirect ? target_aligned : pc_pending;
          state_nxt = FETCH_IDLE;
        end else if (redirect) begin
          pc_pending_nxt = target_aligned;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          valid_nxt = 1'b0;
          count_nxt = count_q + 32'd1;
          state_nxt = FETCH_IDLE;
          if (redirect) pc_nxt = target_aligned;
        end else if (redirect) begin
          valid_nxt = 1'b0;
          pc_nxt    = target_aligned;
          state_nxt = FETCH_IDLE;
        end
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign imem_addr   = pc;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign op          = instr_q[6:0];
  assign F           = instr_q[14:12];
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the fetch unit.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ack;
  logic [31:0] rdata;
  logic        redir;
  logic [31:0] tgt;
  logic        instr_valid;
  logic        rdy;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  F;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model: "outstanding request", "that request is stale", "word buffered"
  bit          m_req, m_drop, m_valid;
  logic [31:0] m_pc, m_pend, m_instr, m_ipc, m_cnt;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (ack),
    .imem_rdata      (rdata),
    .redirect        (redir),
    .redirect_target (tgt),
    .instr_valid     (instr_valid),
    .instr_ready     (rdy),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .op              (op),
    .F               (F),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_drop = 0; m_valid = 0;
    m_pc = 32'h0; m_pend = 32'h0;
    m_instr = 32'h0000_0013; m_ipc = 32'h0; m_cnt = 32'h0;
  endtask

  // Applies the fetch rules for one clock edge to the model.
  task automatic model_update();
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    if (m_req && !m_drop) begin
      if (ack && !redir) begin
        m_instr = rdata; m_ipc = m_pc; m_valid = 1;
        m_pc = m_pc + 32'd4; m_req = 0;
      end else if (ack) begin
        m_pc = t; m_req = 0;
      end else if (redir) begin
        m_drop = 1; m_pend = t;
      end
    end else if (m_req) begin
      if (ack) begin
        m_pc = redir ? t : m_pend; m_req = 0; m_drop = 0;
      end else if (redir) begin
        m_pend = t;
      end
    end else if (m_valid) begin
      if (rdy) begin
        m_cnt = m_cnt + 32'd1; m_valid = 0;
        if (redir) m_pc = t;
      end else if (redir) begin
        m_valid = 0; m_pc = t;
      end
    end else begin
      if (redir) m_pc = t;
      m_req = 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", 32'(imem_req), 32'(m_req));
      if (m_req) chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
      chk("op", 32'(op), 32'(m_instr[6:0]));
      chk("F", 32'(F), 32'(m_instr[14:12]));
      chk("fetch_count", fetch_count, m_cnt);
    end
  end

  // Drive one cycle of inputs, advance the model, return after the edge.
  task automatic step(input logic a, input logic [31:0] d, input logic r,
                      input logic [31:0] t, input logic y);
    ack = a; rdata = d; redir = r; tgt = t; rdy = y;
    model_update();
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 0; ack = 0; rdata = 0; redir = 0; tgt = 0; rdy = 0;
    model_reset();
    @(negedge clk); #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_op", 32'(op), 32'b0010011);
    chk("rst_F", 32'(F), 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk_en = 1;
    @(negedge clk); #1;
    rst_n = 1;

    // first fetch, zero wait, decoder stalls 5 cycles
    step(0, 0, 0, 0, 0);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step(1, 32'h0050_0093, 0, 0, 0);
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_op", 32'(op), 32'b0010011);
    chk("first_F", 32'(F), 32'd0);
    chk("first_pc", instr_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      chk("hold_no_req", 32'(imem_req), 32'd0);
      chk("hold_instr", instr, 32'h0050_0093);
      chk("hold_count", fetch_count, 32'd0);
    end
    step(0, 0, 0, 0, 1);
    chk("hs_count", fetch_count, 32'd1);
    chk("hs_valid", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("next_addr", imem_addr, 32'h4);

    // redirect while waiting for ack
    step(0, 0, 1, 32'h0000_0103, 0);
    chk("drain_addr0", imem_addr, 32'h4);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("drain_addr2", imem_addr, 32'h4);
    chk("drain_req", 32'(imem_req), 32'd1);
    step(1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("drop_valid", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("redir_addr", imem_addr, 32'h100);

    // redirect in HOLD, without then with ready
    step(1, 32'h0020_C0B3, 0, 0, 0);
    chk("xor_op", 32'(op), 32'b0110011);
    chk("xor_F", 32'(F), 32'd4);
    chk("xor_pc", instr_pc, 32'h100);
    step(0, 0, 1, 32'h0000_0200, 0);
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("flush_count", fetch_count, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("flush_addr", imem_addr, 32'h200);
    step(1, 32'h0000_0013, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0300, 1);
    chk("redir_rdy_count", fetch_count, 32'd2);
    step(0, 0, 0, 0, 0);
    chk("redir_rdy_addr", imem_addr, 32'h300);

    // PC wrap
    step(1, 32'h1111_1111, 1, 32'hFFFF_FFFE, 0);
    chk("ack_redir_valid", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    step(1, 32'h0000_00B7, 0, 0, 0);
    chk("top_pc", instr_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);

    // reset asserted mid-DRAIN takes effect without a clock
    step(0, 0, 1, 32'h0000_0040, 0);
    rst_n = 0;
    #1;
    model_reset();
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_instr", instr, 32'h0000_0013);
    chk("arst_count", fetch_count, 32'd0);
    @(negedge clk); #1;
    rst_n = 1;
    step(0, 0, 0, 0, 0);
    chk("restart_addr", imem_addr, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        a, r, y;
      logic [31:0] t;
      a = m_req && ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 5) == 0);
      y = ($urandom_range(0, 1) == 0);
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : $urandom;
      step(a, $urandom, r, t, y);
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the instruction/control path.
- Fetches 32-bit RV32I instructions from instruction memory over a req/ack handshake.
- Holds each fetched word in a one-entry buffer and presents it with its PC, op and funct3 fields to the main decoder over a valid/ready handshake.
- Accepts PC redirects (JAL/JALR/branch) and discards stale fetches.

Parameters:
- XLEN, 32, width of PC and instruction data.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, PC increment per accepted fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  XLEN  fetch address; stable while imem_req=1.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  XLEN  instruction word, valid when imem_ack=1.
- redirect  in  1  single-cycle PC redirect strobe.
- redirect_target  in  XLEN  new PC; bits [1:0] ignored (forced 0).
- instr_valid  out  1  buffered instruction available.
- instr_ready  in  1  decoder accepts the instruction.
- instr  out  XLEN  buffered instruction word.
- instr_pc  out  XLEN  PC of the buffered instruction.
- op  out  7  instr[6:0], combinational from the buffer.
- F  out  3  instr[14:12], combinational from the buffer.
- fetch_count  out  32  count of completed instr handshakes; wraps.

Behaviour:
- Reset values while rst_n=0:
  - pc=RESET_PC; state=FETCH_IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, so op=7'b0010011, F=3'b000.
  - fetch_count=0.
- Reset mid-transaction: all state clears immediately; the outstanding request is abandoned with no drain.
- States:
  - FETCH_IDLE: imem_req=0. Next cycle goes to FETCH (entered from reset or after a handshake).
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_ack & ~redirect: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP, go to HOLD.
    - imem_ack & redirect: data discarded, pc<=target, go to FETCH_IDLE.
    - ~imem_ack & redirect: pc_pending<=target, go to DRAIN.
  - DRAIN: imem_req=1, imem_addr held at the old address (the protocol forbids changing the address or dropping req before ack).
    - imem_ack: data discarded, pc<=pc_pending, go to FETCH_IDLE.
    - A further redirect overwrites pc_pending.
    - Simultaneous ack and redirect: the new target wins.
  - HOLD: instr_valid=1, outputs stable until the handshake completes.
    - instr_valid & instr_ready: instr_valid<=0, fetch_count+=1, go to FETCH_IDLE.
    - redirect & ~instr_ready: instr_valid<=0 (flush), pc<=target, go to FETCH_IDLE, fetch_count unchanged.
    - redirect & instr_ready same cycle: the handshake counts, then pc<=target.
- Latency:
  - Redirect to first imem_req on the new address: 2 cycles when no request is outstanding.
  - ack to instr_valid: 1 cycle.
  - Handshake to next imem_req: 2 cycles (no overlap by design; one-entry buffer, never more than 1 outstanding request).
- Arithmetic: pc+PC_STEP wraps modulo 2^XLEN at 32'hFFFF_FFFC to 0; fetch_count wraps at 2^32-1 to 0.
- Invariants:
  - imem_req never deasserts without imem_ack.
  - instr/instr_pc/op/F never change while instr_valid=1 & ~instr_ready unless a redirect flush occurs.

Decomposition:
- riscv_pkg (shared):
  - fetch state enum {FETCH_IDLE, FETCH, DRAIN, HOLD}.
  - NOP_INSTR = 32'h0000_0013.
  - Opcode constants (OP_R=7'b0110011, OP_I=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111, OP_LUI=7'b0110111), shared with the decoder.
- No sub-module; the FSM, PC register and buffer fit in one module.

Test Plan:
- Reset release, ack after 0 wait cycles with rdata=32'h00500093 -> imem_addr=0, then instr_valid=1, op=7'b0010011, F=0, instr_pc=0, next fetch at addr 4.
- Decoder holds instr_ready=0 for 5 cycles -> instr and op stable; no imem_req during HOLD; fetch_count increments exactly once on the ready cycle.
- Redirect to 32'h0000_0103 while FETCH waits 3 cycles for ack -> addr stays at old PC until ack, data dropped, next request at 32'h0000_0100, instr_valid never set for the dropped word.
- Redirect in HOLD with instr_ready=0 -> instr_valid falls next cycle, fetch_count unchanged, next fetch at target; repeat with instr_ready=1 -> fetch_count+1.
- PC at 32'hFFFF_FFFC acked -> next imem_addr=0; rst_n pulsed low mid-DRAIN -> imem_req=0 and instr=NOP immediately, restart at RESET_PC.
